// File: rtl/sequential_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and a
// constant-evaluable ceil(log2) used to size the bit counter.
package divider_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_e;

   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 32'sd0;
      remaining = value - 32'sd1;
      while (remaining > 32'sd0) begin
         result    = result + 32'sd1;
         remaining = remaining >>> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sequential_divider_trial_subtractor.sv
// Trial subtraction for one restoring-division step: compares the shifted
// partial remainder against the divisor and yields the low bits of the result.
module trial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   minuend,
   input  logic [WIDTH-1:0] subtrahend,
   output logic [WIDTH-1:0] difference,
   output logic             borrow
);

   // When there is no borrow the true difference is below the divisor, so the
   // low WIDTH bits carry the whole result.
   assign borrow     = (minuend < {1'b0, subtrahend});
   assign difference = minuend[WIDTH-1:0] - subtrahend;

endmodule

// File: rtl/sequential_divider.sv
// Unsigned restoring shift-subtract divider, one quotient bit per clock,
// with a Start/Busy/Done handshake and results held until the next Start.
module sequential_divider
   import divider_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             DivByZero
);

   localparam int CNT_W = (clog2(WIDTH) < 32'sd1) ? 32'sd1 : clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] remo_q, remo_d;
   logic             dbz_q, dbz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   shifted_s;
   logic [WIDTH-1:0] diff_s;
   logic             borrow_s;
   logic [WIDTH-1:0] rem_step_s;
   logic [WIDTH-1:0] q_step_s;

   assign shifted_s = {rem_q, q_q[WIDTH-1]};

   trial_subtractor #(
      .WIDTH (WIDTH)
   ) u_trial (
      .minuend    (shifted_s),
      .subtrahend (dvsr_q),
      .difference (diff_s),
      .borrow     (borrow_s)
   );

   // One restoring step: keep the shifted remainder on borrow, else take the difference.
   always_comb begin
      rem_step_s = shifted_s[WIDTH-1:0];
      q_step_s   = {q_q[WIDTH-2:0], ~borrow_s};
      if (borrow_s) begin
         rem_step_s = shifted_s[WIDTH-1:0];
      end else begin
         rem_step_s = diff_s;
      end
   end

   // Next-state and datapath updates; the result registers move only on entry to FIN.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      rem_d   = rem_q;
      q_d     = q_q;
      dvsr_d  = dvsr_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      dbz_d   = dbz_q;
      case (state_q)
         ST_RUN: begin
            rem_d = rem_step_s;
            q_d   = q_step_s;
            if (count_q == {CNT_W{1'b0}}) begin
               state_d = ST_FIN;
               quot_d  = q_step_s;
               remo_d  = rem_step_s;
            end else begin
               count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         ST_IDLE, ST_FIN: begin
            if (Start) begin
               dvsr_d = Divisor;
               if (Divisor == {WIDTH{1'b0}}) begin
                  state_d = ST_FIN;
                  quot_d  = {WIDTH{1'b1}};
                  remo_d  = Dividend;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = ST_RUN;
                  count_d = CNT_INIT;
                  rem_d   = {WIDTH{1'b0}};
                  q_d     = Dividend;
                  dbz_d   = 1'b0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_FIN);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         count_q <= {CNT_W{1'b0}};
         rem_q   <= {WIDTH{1'b0}};
         q_q     <= {WIDTH{1'b0}};
         dvsr_q  <= {WIDTH{1'b0}};
         quot_q  <= {WIDTH{1'b0}};
         remo_q  <= {WIDTH{1'b0}};
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         rem_q   <= rem_d;
         q_q     <= q_d;
         dvsr_q  <= dvsr_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Busy      = busy_q;
   assign Done      = done_q;
   assign Quotient  = quot_q;
   assign Remainder = remo_q;
   assign DivByZero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench: directed cases plus random traffic, all outputs compared
// every cycle against an arithmetic model of the divider's handshake.
module tb_sequential_divider;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             dbz;

   int checks   = 0;
   int failures = 0;

   // Model state: visible outputs, pending result, and cycles left until Done.
   bit               model_on = 1'b0;
   bit               m_busy, m_done, m_dbz;
   logic [WIDTH-1:0] m_q, m_r, p_q, p_r;
   int               m_left;

   always #5 clk = ~clk;

   sequential_divider #(.WIDTH(WIDTH)) dut (
      .Clock     (clk),
      .Reset     (rst),
      .Start     (start),
      .Dividend  (dividend),
      .Divisor   (divisor),
      .Busy      (busy),
      .Done      (done),
      .Quotient  (quotient),
      .Remainder (remainder),
      .DivByZero (dbz)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a division takes WIDTH+1 cycles to Done, divide-by-zero takes 1.
   always @(posedge clk) begin
      if (rst) begin
         m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
         m_q = '0; m_r = '0; m_left = 0;
         model_on = 1'b1;
      end else if (model_on) begin
         if (start && !m_busy) begin
            if (divisor == 0) begin
               m_busy = 1'b0; m_done = 1'b1; m_dbz = 1'b1;
               m_q = '1; m_r = dividend; m_left = 0;
            end else begin
               m_busy = 1'b1; m_done = 1'b0; m_dbz = 1'b0;
               p_q = dividend / divisor; p_r = dividend % divisor;
               m_left = WIDTH;
            end
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0; m_done = 1'b1; m_q = p_q; m_r = p_r;
            end else begin
               m_done = 1'b0;
            end
         end else begin
            m_done = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("quotient", quotient, m_q);
         chk("remainder", remainder, m_r);
         chk("divbyzero", dbz, m_dbz);
      end
   end

   // Wait (bounded) for Done; returns cycles since the accepting edge and Busy cycles seen.
   task automatic wait_done(output int lat, output int busy_cnt);
      int n;
      n = 0; busy_cnt = 0;
      while (!done && n < 40) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         n++;
      end
      if (!done) chk("done_timeout", 32'd0, 32'd1);
      lat = n + 1;
   endtask

   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output int lat, output int busy_cnt);
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, busy_cnt);
   endtask

   initial begin
      int lat, bc, sel;
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_q", quotient, 0);
      chk("reset_r", remainder, 0);
      chk("reset_dbz", dbz, 0);
      rst = 1'b0;

      run_op(8'd100, 8'd7, lat, bc);
      chk("t1_latency", lat, 9);
      chk("t1_busy_cycles", bc, 8);
      chk("t1_q", quotient, 14);
      chk("t1_r", remainder, 2);
      chk("t1_dbz", dbz, 0);
      chk("t1_model_q", m_q, 14);
      chk("t1_model_r", m_r, 2);

      run_op(8'd255, 8'd1, lat, bc);
      chk("t2a_q", quotient, 255);
      chk("t2a_r", remainder, 0);
      chk("t2a_latency", lat, 9);
      run_op(8'd3, 8'd200, lat, bc);
      chk("t2b_q", quotient, 0);
      chk("t2b_r", remainder, 3);
      run_op(8'd255, 8'd255, lat, bc);
      chk("t2c_q", quotient, 1);
      chk("t2c_r", remainder, 0);

      run_op(8'd5, 8'd0, lat, bc);
      chk("t3_latency", lat, 1);
      chk("t3_busy_cycles", bc, 0);
      chk("t3_dbz", dbz, 1);
      chk("t3_q", quotient, 255);
      chk("t3_r", remainder, 5);

      // Start held through RUN with new operands; only the FIN-cycle pulse is taken.
      @(negedge clk);
      start = 1'b1; dividend = 8'd100; divisor = 8'd7;
      @(negedge clk);
      dividend = 8'd9; divisor = 8'd3;
      wait_done(lat, bc);
      chk("t4_latency", lat, 9);
      chk("t4_q", quotient, 14);
      chk("t4_r", remainder, 2);
      @(negedge clk);
      start = 1'b0;
      chk("t4_restart_busy", busy, 1);
      wait_done(lat, bc);
      chk("t4_q2", quotient, 3);
      chk("t4_r2", remainder, 0);

      @(negedge clk);
      start = 1'b1; dividend = 8'd200; divisor = 8'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_busy_before_reset", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      chk("t5_q", quotient, 0);
      chk("t5_r", remainder, 0);
      chk("t5_dbz", dbz, 0);
      run_op(8'd200, 8'd9, lat, bc);
      chk("t5_q_after", quotient, 22);
      chk("t5_r_after", remainder, 2);

      // Random traffic: Start pulses at any time, rare resets, biased edge operands.
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         rst   = ($urandom_range(0, 999) == 0);
         start = ($urandom_range(0, 2) == 0);
         sel = $urandom_range(0, 7);
         dividend = (sel == 0) ? 8'd0 : (sel == 1) ? 8'hFF : 8'($urandom_range(0, 255));
         sel = $urandom_range(0, 7);
         divisor = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd1 : (sel == 2) ? 8'hFF
                   : 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      repeat (12) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
